// File: rtl/draw_command_queue.sv
// Sprite draw command FIFO feeding the graphics accelerator Start/Done handshake.
// End-of-frame markers hold later draws back until the next frame tick.
module draw_command_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_img_id,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic        cmd_eof,
    input  logic        frame_tick,
    output logic [2:0]  img_id,
    output logic [9:0]  imgX,
    output logic [9:0]  imgY,
    output logic        Start,
    input  logic        Done,
    output logic [AW:0] count,
    output logic        empty,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        WAIT_FRAME
    } state_t;

    state_t        state;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [23:0]   head;
    logic          push;
    logic          pop;

    // Full is judged on registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = (count != (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_eof, cmd_img_id, cmd_y, cmd_x};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            Start      <= 1'b0;
            img_id     <= '0;
            imgX       <= '0;
            imgY       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head[23]) begin
                            state <= WAIT_FRAME;
                        end else begin
                            img_id <= head[22:20];
                            imgY   <= head[19:10];
                            imgX   <= head[9:0];
                            Start  <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (Done) begin
                        Start <= 1'b0;
                        state <= RELEASE;
                    end
                end
                // Wait for the accelerator to drop Done before the next command.
                RELEASE: begin
                    if (!Done)
                        state <= IDLE;
                end
                WAIT_FRAME: begin
                    if (frame_tick) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_command_queue.sv
// Bench for draw_command_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_draw_command_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_img_id = '0;
    logic [9:0]  cmd_x = '0;
    logic [9:0]  cmd_y = '0;
    logic        cmd_eof = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  img_id;
    logic [9:0]  imgX;
    logic [9:0]  imgY;
    logic        Start;
    logic        Done = 1'b0;
    logic [AW:0] count;
    logic        empty;
    logic        busy;
    logic        frame_done;

    draw_command_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_img_id(cmd_img_id), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_eof(cmd_eof), .frame_tick(frame_tick),
        .img_id(img_id), .imgX(imgX), .imgY(imgY),
        .Start(Start), .Done(Done),
        .count(count), .empty(empty), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending commands plus what the accelerator is doing.
    logic [23:0] mq[$];
    int          m_phase = 0;  // 0 idle, 1 running, 2 releasing, 3 frame wait
    logic        m_start = 1'b0;
    logic        m_fd = 1'b0;
    logic [2:0]  m_id = '0;
    logic [9:0]  m_x = '0;
    logic [9:0]  m_y = '0;

    logic        acc_done = 1'b0;
    logic        prev_start = 1'b0;
    logic [22:0] prev_args = '0;
    bit          had_start = 1'b0;
    int          low_cnt = 0;
    int          fd_cnt = 0;
    int          issued_x[$];
    logic        a;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mk(input logic e, input logic [2:0] id,
                                       input logic [9:0] x, input logic [9:0] y);
        return {e, id, y, x};
    endfunction

    task automatic model_edge(input logic v, input logic [23:0] d,
                              input logic tk, input logic dn, input logic rst);
        logic        room;
        logic [23:0] e;
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_start = 1'b0;
            m_fd = 1'b0;
            m_id = '0;
            m_x = '0;
            m_y = '0;
            return;
        end
        room = (mq.size() < DEPTH);
        m_fd = 1'b0;
        case (m_phase)
            0: if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e[23]) begin
                    m_phase = 3;
                end else begin
                    m_id = e[22:20];
                    m_y = e[19:10];
                    m_x = e[9:0];
                    m_start = 1'b1;
                    m_phase = 1;
                end
            end
            1: if (dn) begin
                m_start = 1'b0;
                m_phase = 2;
            end
            2: if (!dn) m_phase = 0;
            default: if (tk) begin
                m_fd = 1'b1;
                m_phase = 0;
            end
        endcase
        if (v && room) mq.push_back(d);
    endtask

    task automatic compare_all();
        chk("Start", 32'(Start), 32'(m_start));
        chk("img_id", 32'(img_id), 32'(m_id));
        chk("imgX", 32'(imgX), 32'(m_x));
        chk("imgY", 32'(imgY), 32'(m_y));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
        chk("busy", 32'(busy), 32'(m_phase != 0));
    endtask

    task automatic step(input logic v, input logic [23:0] d, input logic tk,
                        input logic dn, input logic rst, output logic acc);
        @(negedge Clk);
        cmd_valid = v;
        cmd_eof = d[23];
        cmd_img_id = d[22:20];
        cmd_y = d[19:10];
        cmd_x = d[9:0];
        frame_tick = tk;
        Done = dn;
        Reset = rst;
        acc = v && cmd_ready && !rst;
        @(posedge Clk);
        model_edge(v, d, tk, dn, rst);
        #1;
        compare_all();
        if (rst) begin
            had_start = 1'b0;
            low_cnt = 0;
            prev_start = 1'b0;
            acc_done = 1'b0;
        end else begin
            if (Start && prev_start)
                chk("arg_hold", 32'({img_id, imgX, imgY}), 32'(prev_args));
            if (Start && !prev_start) begin
                if (had_start) chk("start_gap", 32'(low_cnt >= 2), 32'd1);
                had_start = 1'b1;
                issued_x.push_back(int'(imgX));
            end
            if (!Start) low_cnt++;
            else low_cnt = 0;
            if (frame_done) fd_cnt++;
            prev_start = Start;
            prev_args = {img_id, imgX, imgY};
        end
    endtask

    // Accelerator stand-in: raises Done some cycles after Start, drops it after Start falls.
    task automatic accel_update(input int spurious_pct);
        if (Start) begin
            if (!acc_done && $urandom_range(2) == 0) acc_done = 1'b1;
        end else if (acc_done) begin
            if ($urandom_range(1) == 0) acc_done = 1'b0;
        end else if (int'($urandom_range(99)) < spurious_pct) begin
            acc_done = 1'b1;
        end
    endtask

    task automatic idle(input logic dn);
        step(1'b0, 24'd0, 1'b0, dn, 1'b0, a);
    endtask

    task automatic drain(input int budget);
        bit   fin;
        logic tk;
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mq.size() == 0 && m_phase == 0 && !acc_done) begin
                fin = 1'b1;
                break;
            end
            accel_update(0);
            tk = ($urandom_range(7) == 0);
            step(1'b0, 24'd0, tk, acc_done, 1'b0, a);
        end
        chk("drain_done", 32'(fin), 32'd1);
    endtask

    initial begin
        int hs;
        int nx;
        int guard;
        logic [23:0] d;
        logic v;
        logic tk;

        // Reset values
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        chk("rst_Start", 32'(Start), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single command, push-to-Start latency of 2
        issued_x.delete();
        step(1'b1, mk(1'b0, 3'd1, 10'd40, 10'd100), 1'b0, 1'b0, 1'b0, a);
        chk("one_count", 32'(count), 32'd1);
        chk("one_nostart", 32'(Start), 32'd0);
        idle(1'b0);
        chk("one_start", 32'(Start), 32'd1);
        chk("one_id", 32'(img_id), 32'd1);
        chk("one_x", 32'(imgX), 32'd40);
        chk("one_y", 32'(imgY), 32'd100);
        repeat (4) idle(1'b0);
        chk("one_hold", 32'(Start), 32'd1);
        idle(1'b1);
        chk("one_fall", 32'(Start), 32'd0);
        chk("one_busy_rel", 32'(busy), 32'd1);
        idle(1'b0);
        chk("one_busy_idle", 32'(busy), 32'd0);

        // Back-to-back commands queued behind a running one
        issued_x.delete();
        step(1'b1, mk(1'b0, 3'd2, 10'd10, 10'd1), 1'b0, 1'b0, 1'b0, a);
        idle(1'b0);
        for (int i = 1; i < 4; i++)
            step(1'b1, mk(1'b0, 3'd2, 10'(10 + i), 10'(i)),
                 1'b0, 1'b0, 1'b0, a);
        drain(200);
        chk("b2b_n", 32'(issued_x.size()), 32'd4);
        for (int i = 0; i < 4 && i < issued_x.size(); i++)
            chk("b2b_order", 32'(issued_x[i]), 32'(10 + i));

        // Fill to full with Done stuck low
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, mk(1'b0, 3'd3, 10'(i), 10'(i)), 1'b0, 1'b0, 1'b0, a);
            if (a) hs++;
        end
        chk("full_hs", 32'(hs), 32'd17);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        idle(1'b1);
        chk("full_ready_rel", 32'(cmd_ready), 32'd0);
        idle(1'b0);
        chk("full_ready_idle", 32'(cmd_ready), 32'd0);
        idle(1'b0);
        chk("full_ready_pop", 32'(cmd_ready), 32'd1);
        chk("full_count_pop", 32'(count), 32'd15);
        drain(2000);

        // EOF gating
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        fd_cnt = 0;
        step(1'b1, mk(1'b0, 3'd3, 10'd100, 10'd200), 1'b0, 1'b0, 1'b0, a);
        step(1'b1, mk(1'b1, 3'd0, 10'd0, 10'd0), 1'b0, 1'b0, 1'b0, a);
        chk("eof_a_start", 32'(Start), 32'd1);
        chk("eof_a_x", 32'(imgX), 32'd100);
        step(1'b1, mk(1'b0, 3'd4, 10'd300, 10'd400), 1'b0, 1'b0, 1'b0, a);
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, a);
        chk("eof_tick_issue", 32'(frame_done), 32'd0);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, a);
        chk("eof_wait_busy", 32'(busy), 32'd1);
        chk("eof_tick_at_pop", 32'(frame_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("eof_gated", 32'(Start), 32'd0);
        end
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, a);
        chk("eof_fd", 32'(frame_done), 32'd1);
        chk("eof_fd_nostart", 32'(Start), 32'd0);
        idle(1'b0);
        chk("eof_b_start", 32'(Start), 32'd1);
        chk("eof_b_x", 32'(imgX), 32'd300);
        chk("eof_b_y", 32'(imgY), 32'd400);
        chk("eof_fd_off", 32'(frame_done), 32'd0);
        idle(1'b1);
        idle(1'b0);
        chk("eof_fd_pulses", 32'(fd_cnt), 32'd1);

        // Pointer wrap: 40 commands in order
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        issued_x.delete();
        nx = 0;
        guard = 0;
        while (nx < 40 && guard < 5000) begin
            v = ($urandom_range(1) == 1);
            accel_update(0);
            d = mk(1'b0, 3'(nx), 10'(nx), 10'(39 - nx));
            step(v, d, 1'b0, acc_done, 1'b0, a);
            if (a) nx++;
            guard++;
        end
        chk("wrap_pushed", 32'(nx), 32'd40);
        drain(3000);
        chk("wrap_n", 32'(issued_x.size()), 32'd40);
        for (int i = 0; i < 40 && i < issued_x.size(); i++)
            chk("wrap_order", 32'(issued_x[i]), 32'(i));

        // Reset mid-ISSUE with 5 queued
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        for (int i = 0; i < 6; i++)
            step(1'b1, mk(1'b0, 3'd5, 10'(i), 10'(i)), 1'b0, 1'b0, 1'b0, a);
        chk("mid_start", 32'(Start), 32'd1);
        chk("mid_count", 32'(count), 32'd5);
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        chk("mid_rst_start", 32'(Start), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 10; i++) begin
            accel_update(5);
            step(1'b0, 24'd0, 1'b0, acc_done, 1'b0, a);
            chk("mid_no_start", 32'(Start), 32'd0);
        end

        // Randomized traffic
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, a);
        for (int i = 0; i < 1500; i++) begin
            accel_update(3);
            v = ($urandom_range(1) == 1);
            d = mk($urandom_range(9) == 0, 3'($urandom_range(7)),
                   10'($urandom_range(1023)), 10'($urandom_range(1023)));
            tk = ($urandom_range(9) == 0);
            step(v, d, tk, acc_done, 1'b0, a);
        end
        drain(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
